// File: rtl/score_digit_driver.sv
// score_digit_driver
//   Score-side front end of the HUD digit renderer. A sequential
//   double-dabble engine turns the binary score into BCD. The raster
//   position from the VGA controller selects a glyph code and a pixel
//   index for the 10x10 digit ROM. A three-stage aligned pixel enable
//   goes back to the colour mux.
//
// Ports
//   clock_25         pixel clock
//   reset_n          asynchronous reset, active low
//   score            binary score, captured on an accepted score_load
//   score_load       one-cycle conversion request (ignored while busy)
//   busy             conversion in progress
//   digits_bcd       displayed BCD digits, MS nibble = leftmost digit
//   h_count/v_count  current raster column/row
//   selected_number  glyph code to the ROM (0-9, 10 = blank)
//   number_count     glyph pixel index to the ROM, row*10+col
//   number_pixel     ROM pixel bit
//   score_pixel_en   draw score colour for the raster sample 3 cycles back
module score_digit_driver #(
  parameter int SCORE_W = 10,
  parameter int DIGITS  = 3,
  parameter int X0      = 500,
  parameter int Y0      = 20,
  parameter int GAP     = 2
) (
  input  logic                  clock_25,
  input  logic                  reset_n,
  input  logic [SCORE_W-1:0]    score,
  input  logic                  score_load,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   digits_bcd,
  input  logic [9:0]            h_count,
  input  logic [9:0]            v_count,
  output logic [3:0]            selected_number,
  output logic [7:0]            number_count,
  input  logic                  number_pixel,
  output logic                  score_pixel_en
);

  localparam int          PITCH = 10 + GAP;
  localparam int          BW    = 4 * DIGITS;
  localparam int          CW    = $clog2(SCORE_W + 1);
  localparam int unsigned MAXV  = 10**DIGITS - 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state_q, state_d;
  logic [SCORE_W-1:0]   bin_q, bin_d;
  logic [BW-1:0]        bcd_q, bcd_d;
  logic [BW-1:0]        adj;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 sat_q, sat_d;
  logic [BW-1:0]        digits_q, digits_d;
  logic                 arm_q;

  logic [3:0]           code_arr [DIGITS];
  logic [10:0]          hx, vy;
  logic                 in_glyph;
  logic [3:0]           col, code_c;
  logic [6:0]           idx_c;

  logic [3:0]           sel_q, sel_d;
  logic [6:0]           idx_p1_q, idx_p1_d;
  logic                 vld_p1_q, vld_p1_d;
  logic [7:0]           number_count_q, number_count_d;
  logic                 vld_p2_q, vld_p2_d;
  logic                 en_q, en_d;

  // Add 3 to every BCD nibble that is 5 or more (double-dabble correction).
  function automatic logic [BW-1:0] add3_all(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Values too large for the display clamp to all nines.
  function automatic logic [BW-1:0] sat_digits(input logic [BW-1:0] b, input logic sat);
    return sat ? {DIGITS{4'h9}} : b;
  endfunction

  // Conversion FSM
  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    digits_d = digits_q;
    adj      = add3_all(bcd_q);
    case (state_q)
      IDLE: begin
        // arm_q keeps a load coinciding with the first edge after reset release from starting.
        if (score_load && arm_q) begin
          bin_d   = score;
          bcd_d   = '0;
          cnt_d   = '0;
          sat_d   = (32'(score) > MAXV);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Only DIGITS nibbles are kept: any value that would need more is saturated anyway.
        bcd_d = {adj[BW-2:0], bin_q[SCORE_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(SCORE_W - 1)) state_d = DONE;
      end
      DONE: begin
        digits_d = sat_digits(bcd_q, sat_q);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      digits_q <= '0;
      arm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      digits_q <= digits_d;
      arm_q    <= 1'b1;
    end
  end

  // Glyph codes with leading-zero blanking; the rightmost digit always shows.
  always_comb begin
    logic       lead;
    logic [3:0] nib;
    lead = 1'b0;
    nib  = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      code_arr[i] = 4'd10;
      nib = digits_q[4*(DIGITS-1-i) +: 4];
      if (lead || nib != 4'd0 || i == DIGITS - 1) begin
        code_arr[i] = nib;
        lead        = 1'b1;
      end
    end
  end

  // Stage 0: raster position -> digit cell, glyph column and row
  always_comb begin
    hx       = {1'b0, h_count} - 11'(X0);
    vy       = {1'b0, v_count} - 11'(Y0);
    in_glyph = 1'b0;
    col      = 4'd0;
    code_c   = 4'd0;
    // A negative difference shows up as bit 10 set; each cell is matched by range compare.
    if (!hx[10] && !vy[10] && vy < 11'd10) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (hx >= 11'(i*PITCH) && hx < 11'(i*PITCH + 10)) begin
          in_glyph = 1'b1;
          col      = 4'(hx - 11'(i*PITCH));
          code_c   = code_arr[i];
        end
      end
    end
    idx_c = 7'({vy[3:0], 3'b000}) + 7'({vy[3:0], 1'b0}) + 7'(col);
  end

  always_comb begin
    sel_d          = in_glyph ? code_c : 4'd0;
    idx_p1_d       = in_glyph ? idx_c  : 7'd0;
    vld_p1_d       = in_glyph;
    number_count_d = {1'b0, idx_p1_q};
    vld_p2_d       = vld_p1_q;
    en_d           = vld_p2_q & number_pixel;
  end

  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      sel_q          <= 4'd0;
      idx_p1_q       <= 7'd0;
      vld_p1_q       <= 1'b0;
      number_count_q <= 8'd0;
      vld_p2_q       <= 1'b0;
      en_q           <= 1'b0;
    end else begin
      // Stage 1: code to ROM, index held until the ROM has latched the code
      sel_q          <= sel_d;
      idx_p1_q       <= idx_p1_d;
      vld_p1_q       <= vld_p1_d;
      // Stage 2: index presented alongside the latched glyph
      number_count_q <= number_count_d;
      vld_p2_q       <= vld_p2_d;
      // Stage 3: gated ROM pixel
      en_q           <= en_d;
    end
  end

  assign busy            = (state_q != IDLE);
  assign digits_bcd      = digits_q;
  assign selected_number = sel_q;
  assign number_count    = number_count_q;
  assign score_pixel_en  = en_q;

endmodule

// File: tb/tb_score_digit_driver.sv
module tb_score_digit_driver;
  localparam int X0     = 500;
  localparam int Y0     = 20;
  localparam int GAP    = 2;
  localparam int PITCH  = 10 + GAP;
  localparam int DIGITS = 3;

  logic        clock_25 = 1'b0;
  logic        reset_n  = 1'b0;
  logic [9:0]  score    = '0;
  logic        score_load = 1'b0;
  logic        busy;
  logic [11:0] digits_bcd;
  logic [9:0]  h_count = '0;
  logic [9:0]  v_count = '0;
  logic [3:0]  selected_number;
  logic [7:0]  number_count;
  logic        number_pixel;
  logic        score_pixel_en;

  int total = 0;
  int bad   = 0;
  int shown = 0;

  bit         rom [0:10][0:99];
  logic [3:0] rom_code = 4'd0;

  score_digit_driver #(.SCORE_W(10), .DIGITS(DIGITS), .X0(X0), .Y0(Y0), .GAP(GAP)) dut (
    .clock_25(clock_25), .reset_n(reset_n), .score(score), .score_load(score_load),
    .busy(busy), .digits_bcd(digits_bcd), .h_count(h_count), .v_count(v_count),
    .selected_number(selected_number), .number_count(number_count),
    .number_pixel(number_pixel), .score_pixel_en(score_pixel_en)
  );

  always #20 clock_25 = ~clock_25;

  // Glyph ROM: code latched on the clock, pixel index combinational.
  always @(posedge clock_25) rom_code <= selected_number;
  assign number_pixel = (rom_code <= 4'd10 && number_count < 8'd100) ?
                        rom[rom_code][number_count[6:0]] : 1'b0;

  task automatic tick;
    @(posedge clock_25);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int to_bcd(input int v);
    return ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  // Glyph code for display position i (0 = leftmost) of value val.
  function automatic int model_code(input int val, input int i);
    int p;
    p = 10**(DIGITS - 1 - i);
    if (i == DIGITS - 1 || val >= p) return (val / p) % 10;
    return 10;
  endfunction

  // Load a score and follow the conversion; optionally pulse a second load mid-conversion.
  task automatic load(input int s, input int pulse_at, input int second);
    int n;
    logic [11:0] prev;
    prev = digits_bcd;
    score = 10'(s);
    score_load = 1'b1;
    tick;
    score_load = 1'b0;
    n = 0;
    while (busy && n < 60) begin
      check("atomic_digits", digits_bcd, prev);
      n++;
      if (n == pulse_at) begin
        score = 10'(second);
        score_load = 1'b1;
      end
      tick;
      score_load = 1'b0;
    end
    shown = (s > 999) ? 999 : s;
    check("busy_len", n, 11);
    check("digits_bcd", digits_bcd, to_bcd(shown));
  endtask

  task automatic raster(input int h, input int v);
    int hx, vy, d, col, idx, code;
    bit in_g;
    h_count = 10'(h);
    v_count = 10'(v);
    hx = h - X0;
    vy = v - Y0;
    in_g = (hx >= 0) && (vy >= 0) && (vy < 10) && (hx < DIGITS * PITCH) && ((hx % PITCH) < 10);
    d = 0; col = 0; idx = 0; code = 0;
    if (in_g) begin
      d    = hx / PITCH;
      col  = hx % PITCH;
      idx  = vy * 10 + col;
      code = model_code(shown, d);
    end
    tick;
    check("selected_number", selected_number, in_g ? code : 0);
    tick;
    check("number_count", number_count, in_g ? idx : 0);
    tick;
    check("score_pixel_en", score_pixel_en, in_g ? 32'(rom[code][idx]) : 0);
  endtask

  initial begin
    for (int c = 0; c < 11; c++)
      for (int i = 0; i < 100; i++)
        rom[c][i] = (c == 10) ? 1'b0 : 1'($urandom_range(0, 1));

    // Reset state
    repeat (3) tick;
    check("rst_busy", busy, 0);
    check("rst_digits", digits_bcd, 0);
    check("rst_sel", selected_number, 0);
    check("rst_count", number_count, 0);
    check("rst_en", score_pixel_en, 0);
    @(negedge clock_25);
    reset_n = 1'b1;
    tick;
    tick;

    // Plain conversion and pixel path
    load(123, 0, 0);
    raster(X0 + 21, Y0 + 2);
    raster(X0 + 10, Y0);
    raster(X0 - 1, Y0 + 5);
    raster(X0 + 5, Y0 + 10);
    raster(X0 + 34, Y0 + 9);
    raster(X0 + 33, Y0 + 9);
    raster(X0, Y0);

    // Saturation and leading-zero blanking
    load(1023, 0, 0);
    raster(X0 + 4, Y0 + 4);
    load(0, 0, 0);
    raster(X0 + 3, Y0 + 3);
    raster(X0 + 15, Y0 + 3);
    raster(X0 + 27, Y0 + 3);
    load(7, 0, 0);
    raster(X0 + 15, Y0 + 6);
    raster(X0 + 28, Y0 + 6);

    // Load during busy is dropped
    load(456, 5, 7);
    raster(X0 + 13, Y0 + 1);

    // Randomised scores and raster positions
    repeat (6) begin
      load(int'($urandom_range(0, 1023)), 0, 0);
      repeat (10) raster(X0 - 4 + int'($urandom_range(0, 44)), Y0 - 2 + int'($urandom_range(0, 14)));
      raster(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)));
    end

    // Asynchronous reset in the middle of a conversion
    h_count = 10'(X0 + 2);
    v_count = 10'(Y0 + 2);
    score = 10'd999;
    score_load = 1'b1;
    tick;
    score_load = 1'b0;
    repeat (3) tick;
    #5;
    reset_n = 1'b0;
    #1;
    check("async_busy", busy, 0);
    check("async_digits", digits_bcd, 0);
    check("async_en", score_pixel_en, 0);
    check("async_count", number_count, 0);
    shown = 0;

    // Load held across reset release is not taken on the first edge
    score = 10'd5;
    score_load = 1'b1;
    @(negedge clock_25);
    reset_n = 1'b1;
    tick;
    score_load = 1'b0;
    check("release_load_busy", busy, 0);
    tick;
    check("release_load_busy2", busy, 0);
    check("release_digits", digits_bcd, 0);

    // Recovery after reset
    load(42, 0, 0);
    raster(X0 + 14, Y0 + 8);
    raster(X0 + 26, Y0 + 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
